spike_scanner: RTL

SPIKE_SCANNER -- requirements
Module: spike_scanner

---
 rtl/snn_pkg.sv | 15 +
 rtl/prio_enc_lsb.sv | 23 ++
 rtl/spike_scanner.sv | 123 ++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared constants and state encoding for the spike scanner slice.
// Sized for a 256-axon crossbar input row.
package snn_pkg;

    localparam int NUM_AXONS  = 256;
    localparam int AXON_IDX_W = $clog2(NUM_AXONS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_EMIT,
        ST_DONE
    } scan_state_e;

endpackage

// File: rtl/prio_enc_lsb.sv
// Combinational lowest-set-bit encoder.
// idx is zero and any_o is low when vec is all zeros.
module prio_enc_lsb #(
    parameter int NUM_AXONS  = snn_pkg::NUM_AXONS,
    parameter int AXON_IDX_W = snn_pkg::AXON_IDX_W
) (
    input  logic [NUM_AXONS-1:0]  vec,
    output logic [AXON_IDX_W-1:0] idx,
    output logic                  any_o
);

    always_comb begin
        idx   = '0;
        any_o = |vec;
        // Walk downward so the lowest set bit is the last write.
        for (int i = NUM_AXONS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = AXON_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/spike_scanner.sv
// Snapshots a spike vector and emits set-bit indices in ascending order.
// Optional abort_i port is added when SPIKE_SCANNER_ABORT_EN is defined.
module spike_scanner #(
    parameter int NUM_AXONS  = snn_pkg::NUM_AXONS,
    parameter int AXON_IDX_W = snn_pkg::AXON_IDX_W
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  start_i,
    input  logic [NUM_AXONS-1:0]  spike_axon_i,
    output logic [AXON_IDX_W-1:0] axon_idx_o,
    output logic                  axon_valid_o,
    input  logic                  axon_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [AXON_IDX_W:0]   spike_count_o
`ifdef SPIKE_SCANNER_ABORT_EN
    ,
    input  logic                  abort_i
`endif
);

    import snn_pkg::*;

    scan_state_e             state_q, state_d;
    logic [NUM_AXONS-1:0]    shadow_q, shadow_d;
    logic [AXON_IDX_W-1:0]   idx_q, idx_d;
    logic                    valid_q, valid_d;
    logic                    done_q, done_d;
    logic [AXON_IDX_W:0]     count_q, count_d;

    logic [AXON_IDX_W-1:0]   enc_idx;
    logic                    enc_any;

    prio_enc_lsb #(
        .NUM_AXONS  (NUM_AXONS),
        .AXON_IDX_W (AXON_IDX_W)
    ) u_enc (
        .vec   (shadow_q),
        .idx   (enc_idx),
        .any_o (enc_any)
    );

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        count_d  = count_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    shadow_d = spike_axon_i;
                    count_d  = '0;
                    state_d  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!enc_any) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = enc_idx;
                    valid_d = 1'b1;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (axon_ready_i) begin
                    shadow_d[idx_q] = 1'b0;
                    count_d         = count_q + 1'b1;
                    valid_d         = 1'b0;
                    state_d         = ST_SCAN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

`ifdef SPIKE_SCANNER_ABORT_EN
        // Abort keeps the accepted count so software can see progress.
        if (abort_i && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            shadow_d = '0;
            valid_d  = 1'b0;
            done_d   = 1'b0;
            count_d  = count_q;
        end
`endif
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            count_q  <= count_d;
        end
    end

    assign axon_idx_o    = idx_q;
    assign axon_valid_o  = valid_q;
    assign done_o        = done_q;
    assign spike_count_o = count_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule
